// File: rtl/mcu_cmd_chan.sv
// ---------------------------------------------------------------------------
// mcu_cmd_chan
//
// MCU command channel for an SPI-attached memory controller. It decodes SPI
// command bytes and keeps NCH address pointers, each with a wrap limit. It
// issues single-byte memory read and write requests and lets an SD-DMA engine
// advance one selected pointer.
//
// Command byte (cmd_data[7:4] selects the operation):
//   0x0t  load addr[t], MSB first, one byte per parameter
//   0x4t  select channel t as the DMA target and enable DMA
//         (a later parameter byte disables DMA)
//   0x5t  load limit[t], MSB first
//   0x7t  read back a snapshot of addr[t], MSB first
//   0x8x  memory read  (bit 3 = auto-increment, bit 0 = skip first increment)
//   0x9x  memory write (same flag bits)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_ready, cmd_data      command byte strobe and value (SPI byte 1)
//   param_ready, param_data  parameter byte strobe and value (SPI bytes 2+)
//   spi_byte_cnt             index of the current SPI byte (command = 1)
//   mcu_rq_rdy, mcu_data_in  memory completion level and read data
//   dma_nextaddr             pulse that advances addr[dma_tgt]
//   mcu_rrq, mcu_wrq         single-cycle read and write request pulses
//   mcu_data_out             write data for the memory
//   spi_data_out             readback byte returned to the MCU
//   addr_out                 all channel addresses, channel c at [c*AW +: AW]
//   dma_tgt, dma_en          DMA target channel and enable
//   busy                     a memory request is in flight
// ---------------------------------------------------------------------------
module mcu_cmd_chan #(
    parameter int NCH = 4,
    parameter int AW  = 24,
    parameter int NB  = (AW + 7) / 8,
    parameter int TW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_ready,
    input  logic              param_ready,
    input  logic [7:0]        cmd_data,
    input  logic [7:0]        param_data,
    input  logic [31:0]       spi_byte_cnt,
    input  logic              mcu_rq_rdy,
    input  logic [7:0]        mcu_data_in,
    input  logic              dma_nextaddr,
    output logic              mcu_rrq,
    output logic              mcu_wrq,
    output logic [7:0]        mcu_data_out,
    output logic [7:0]        spi_data_out,
    output logic [NCH*AW-1:0] addr_out,
    output logic [TW-1:0]     dma_tgt,
    output logic              dma_en,
    output logic              busy
);

    // Addresses are handled as NB whole bytes, MSB-aligned, so a width that is
    // not a multiple of 8 drops the low bits of the last byte.
    localparam int         PW          = NB * 8;
    localparam logic [4:0] NCH_L       = 5'(NCH);
    localparam logic [31:0] LAST_BYTE  = 32'(NB + 1);
    localparam bit         CH_FROM_CMD = (NCH <= 8);

    typedef enum logic [1:0] {S_IDLE, S_RQ, S_WAIT} state_t;

    // Request details captured when a transfer starts.
    typedef struct packed {
        logic          rd;
        logic [TW-1:0] ch;
        logic          inc;
        logic          skip;
    } req_ctx_t;

    // Write byte k (2 = MSB) of an address value. Byte 2 starts a fresh
    // value, so the bytes below it are cleared.
    function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] val,
                                               input logic [31:0]   k,
                                               input logic [7:0]    b);
        logic [PW-1:0] full;
        int            pos;
        full = PW'(val) << (PW - AW);
        if (k == 32'd2) full = '0;
        pos = PW - 8 * (int'(k) - 1);
        if (pos >= 0 && pos <= PW - 8) full[pos +: 8] = b;
        return full[PW-1 -: AW];
    endfunction

    // Read byte k (2 = MSB) of an address value; other indices read as zero.
    function automatic logic [7:0] get_byte(input logic [AW-1:0] val,
                                            input logic [31:0]   k);
        logic [PW-1:0] full;
        int            pos;
        full = PW'(val) << (PW - AW);
        pos  = PW - 8 * (int'(k) - 1);
        if (pos >= 0 && pos <= PW - 8) return full[pos +: 8];
        return 8'h00;
    endfunction

    // Step to the next address, wrapping to zero once the limit is reached.
    function automatic logic [AW-1:0] advance(input logic [AW-1:0] val,
                                              input logic [AW-1:0] lim);
        return (val == lim) ? '0 : val + AW'(1);
    endfunction

    state_t        state, state_nxt;
    req_ctx_t      ctx;
    logic [AW-1:0] addr    [NCH];
    logic [AW-1:0] limit   [NCH];
    logic [NCH-1:0] pending;
    logic [AW-1:0] snap;
    logic [1:0]    rdy_hist;

    logic [3:0]    op;
    logic [TW-1:0] t_ch;
    logic          t_ok;
    logic [TW-1:0] rq_ch;
    logic          rq_ok;
    logic          in_rng;
    logic          rdy_edge;
    logic          start_rq;
    logic          done_rq;
    logic          mcu_adv;
    logic [NCH-1:0] ld_addr, ld_lim, dma_hit, mcu_hit;

    assign op    = cmd_data[7:4];
    assign t_ch  = cmd_data[TW-1:0];
    // The whole low nibble must name an existing channel, so e.g. 0x0F is
    // rejected on a 4-channel build even though its low TW bits are in range.
    assign t_ok  = {1'b0, cmd_data[3:0]} < NCH_L;
    assign rq_ch = CH_FROM_CMD ? cmd_data[TW-1:0] : '0;
    assign rq_ok = {{(5-TW){1'b0}}, rq_ch} < NCH_L;
    assign in_rng   = (spi_byte_cnt >= 32'd2) && (spi_byte_cnt <= LAST_BYTE);
    assign rdy_edge = rdy_hist[0] & ~rdy_hist[1];

    // Request FSM: next state and start/finish events.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that skips an assignment would infer a latch.
        state_nxt = state;
        start_rq  = 1'b0;
        done_rq   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rq_ok && ((op == 4'h8 && (cmd_ready || param_ready)) ||
                              (op == 4'h9 && param_ready))) begin
                    state_nxt = S_RQ;
                    start_rq  = 1'b1;
                end
            end
            S_RQ:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (rdy_edge) begin
                    state_nxt = S_IDLE;
                    done_rq   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The skip flag suppresses the increment of the first transfer, which
    // happens before byte 3 of the SPI transaction.
    assign mcu_adv = done_rq && ctx.inc && (!ctx.skip || spi_byte_cnt >= 32'd3);

    // Per-channel load and advance requests.
    always_comb begin
        ld_addr = '0;
        ld_lim  = '0;
        dma_hit = '0;
        mcu_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            ld_addr[c] = param_ready && in_rng && t_ok && op == 4'h0 && t_ch == TW'(c);
            ld_lim[c]  = param_ready && in_rng && t_ok && op == 4'h5 && t_ch == TW'(c);
            dma_hit[c] = dma_nextaddr && dma_tgt == TW'(c);
            mcu_hit[c] = mcu_adv && ctx.ch == TW'(c);
        end
    end

    always_comb begin
        addr_out = '0;
        for (int c = 0; c < NCH; c++) addr_out[c*AW +: AW] = addr[c];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the address and limit arrays are a handful of registers
            // with defined power-up values, so they are reset like any other
            // state rather than left to a memory macro.
            for (int c = 0; c < NCH; c++) begin
                addr[c]  <= '0;
                limit[c] <= '1;
            end
            pending      <= '0;
            snap         <= '0;
            ctx          <= '0;
            rdy_hist     <= '0;
            dma_tgt      <= '0;
            dma_en       <= 1'b0;
            mcu_rrq      <= 1'b0;
            mcu_wrq      <= 1'b0;
            mcu_data_out <= '0;
            spi_data_out <= '0;
            busy         <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            rdy_hist <= {rdy_hist[0], mcu_rq_rdy};

            // Priority per channel: load, then DMA (deferring a colliding
            // MCU advance by one cycle), then a deferred advance, then MCU.
            for (int c = 0; c < NCH; c++) begin
                if (ld_addr[c]) begin
                    addr[c]    <= put_byte(addr[c], spi_byte_cnt, param_data);
                    pending[c] <= 1'b0;
                end else if (dma_hit[c]) begin
                    addr[c] <= advance(addr[c], limit[c]);
                    if (mcu_hit[c]) pending[c] <= 1'b1;
                end else if (pending[c]) begin
                    addr[c]    <= advance(addr[c], limit[c]);
                    pending[c] <= mcu_hit[c];
                end else if (mcu_hit[c]) begin
                    addr[c] <= advance(addr[c], limit[c]);
                end
                if (ld_lim[c]) limit[c] <= put_byte(limit[c], spi_byte_cnt, param_data);
            end

            if (cmd_ready && op == 4'h4 && t_ok) begin
                dma_tgt <= t_ch;
                dma_en  <= 1'b1;
            end else if (param_ready && op == 4'h4) begin
                dma_en <= 1'b0;
            end

            if (cmd_ready && op == 4'h7 && t_ok) snap <= addr[t_ch];

            if (done_rq && ctx.rd)
                spi_data_out <= mcu_data_in;
            else if (param_ready && op == 4'h7 && t_ok)
                spi_data_out <= get_byte(snap, spi_byte_cnt);

            if (start_rq) begin
                ctx.rd   <= (op == 4'h8);
                ctx.ch   <= rq_ch;
                ctx.inc  <= cmd_data[3];
                ctx.skip <= cmd_data[0];
                if (op == 4'h9) mcu_data_out <= param_data;
            end
            mcu_rrq <= start_rq && op == 4'h8;
            mcu_wrq <= start_rq && op == 4'h9;
            busy    <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_mcu_cmd_chan.sv
// ---------------------------------------------------------------------------
// tb_mcu_cmd_chan
//
// Directed bench for mcu_cmd_chan with default parameters (4 channels,
// 24-bit addresses). Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_mcu_cmd_chan;

    localparam int NCH = 4;
    localparam int AW  = 24;
    localparam int TW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_ready = 1'b0;
    logic              param_ready = 1'b0;
    logic [7:0]        cmd_data = '0;
    logic [7:0]        param_data = '0;
    logic [31:0]       spi_byte_cnt = '0;
    logic              mcu_rq_rdy = 1'b0;
    logic [7:0]        mcu_data_in = '0;
    logic              dma_nextaddr = 1'b0;
    logic              mcu_rrq;
    logic              mcu_wrq;
    logic [7:0]        mcu_data_out;
    logic [7:0]        spi_data_out;
    logic [NCH*AW-1:0] addr_out;
    logic [TW-1:0]     dma_tgt;
    logic              dma_en;
    logic              busy;

    mcu_cmd_chan #(.NCH(NCH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_ready    (cmd_ready),
        .param_ready  (param_ready),
        .cmd_data     (cmd_data),
        .param_data   (param_data),
        .spi_byte_cnt (spi_byte_cnt),
        .mcu_rq_rdy   (mcu_rq_rdy),
        .mcu_data_in  (mcu_data_in),
        .dma_nextaddr (dma_nextaddr),
        .mcu_rrq      (mcu_rrq),
        .mcu_wrq      (mcu_wrq),
        .mcu_data_out (mcu_data_out),
        .spi_data_out (spi_data_out),
        .addr_out     (addr_out),
        .dma_tgt      (dma_tgt),
        .dma_en       (dma_en),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rrq_cnt  = 0;
    int wrq_cnt  = 0;
    int rrq_base;
    int wrq_base;

    always @(negedge clk) begin
        if (mcu_rrq) rrq_cnt <= rrq_cnt + 1;
        if (mcu_wrq) wrq_cnt <= wrq_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ch_addr(input int c);
        return 32'(addr_out[c*AW +: AW]);
    endfunction

    task automatic do_cmd(input logic [7:0] c);
        cmd_data     = c;
        spi_byte_cnt = 32'd1;
        cmd_ready    = 1'b1;
        tick();
        cmd_ready    = 1'b0;
    endtask

    task automatic do_param(input logic [7:0] p, input int k);
        param_data   = p;
        spi_byte_cnt = 32'(k);
        param_ready  = 1'b1;
        tick();
        param_ready  = 1'b0;
    endtask

    task automatic load3(input logic [7:0] c, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
        do_cmd(c);
        do_param(b2, 2);
        do_param(b3, 3);
        do_param(b4, 4);
    endtask

    // Bounded wait for the request FSM to return to idle.
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!busy) break;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_addr_lo", addr_out[63:0], 64'd0);
        check("rst_addr_hi", 32'(addr_out[95:64]), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dma_en", 32'(dma_en), 32'd0);
        check("rst_dma_tgt", 32'(dma_tgt), 32'd0);
        check("rst_spi", 32'(spi_data_out), 32'd0);
        check("rst_dout", 32'(mcu_data_out), 32'd0);
        check("rst_rq", 32'({mcu_rrq, mcu_wrq}), 32'd0);
        rst = 1'b0;
        tick();

        // Address load, MSB first; extra bytes ignored
        load3(8'h02, 8'h12, 8'h34, 8'h56);
        check("load_ch2", ch_addr(2), 32'h123456);
        check("load_ch0_untouched", ch_addr(0), 32'h0);
        do_param(8'h99, 5);
        check("load_byte5_ignored", ch_addr(2), 32'h123456);

        // Out-of-range channel command is ignored
        do_cmd(8'h0F);
        do_param(8'h11, 2);
        check("ign_0f_ch3", ch_addr(3), 32'h0);
        check("ign_0f_ch2", ch_addr(2), 32'h123456);

        // Read with auto-increment wrapping at the limit
        load3(8'h00, 8'h00, 8'hFF, 8'hFF);
        load3(8'h50, 8'h00, 8'hFF, 8'hFF);
        check("load_ch0", ch_addr(0), 32'h00FFFF);
        rrq_base = rrq_cnt;
        do_cmd(8'h88);
        check("rd_rrq_hi", 32'(mcu_rrq), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        tick();
        check("rd_rrq_one_cycle", 32'(mcu_rrq), 32'd0);
        do_param(8'h00, 2);
        check("rd_drop_busy_strobe", 32'(rrq_cnt - rrq_base), 32'd1);
        mcu_data_in = 8'hA5;
        mcu_rq_rdy  = 1'b1;
        wait_idle("rd_done");
        check("rd_spi_data", 32'(spi_data_out), 32'hA5);
        check("rd_wrap_addr", ch_addr(0), 32'h0);
        check("rd_rrq_pulses", 32'(rrq_cnt - rrq_base), 32'd1);
        mcu_rq_rdy = 1'b0;
        tick();
        tick();

        // Write with auto-increment
        wrq_base = wrq_cnt;
        do_cmd(8'h98);
        check("wr_no_start_on_cmd", 32'(busy), 32'd0);
        do_param(8'h3C, 2);
        check("wr_wrq_hi", 32'(mcu_wrq), 32'd1);
        check("wr_dout", 32'(mcu_data_out), 32'h3C);
        tick();
        mcu_rq_rdy = 1'b1;
        wait_idle("wr_done");
        check("wr_inc_addr", ch_addr(0), 32'h1);
        check("wr_spi_kept", 32'(spi_data_out), 32'hA5);
        check("wr_wrq_pulses", 32'(wrq_cnt - wrq_base), 32'd1);
        mcu_rq_rdy = 1'b0;
        tick();
        tick();

        // Readback snapshot
        load3(8'h01, 8'hAB, 8'hCD, 8'hEF);
        do_cmd(8'h71);
        do_param(8'h00, 2);
        check("rb_b2", 32'(spi_data_out), 32'hAB);
        do_param(8'h00, 3);
        check("rb_b3", 32'(spi_data_out), 32'hCD);
        do_param(8'h00, 4);
        check("rb_b4", 32'(spi_data_out), 32'hEF);
        do_param(8'h00, 5);
        check("rb_b5", 32'(spi_data_out), 32'h00);

        // DMA and MCU advance collide on channel 1
        load3(8'h01, 8'h00, 8'h00, 8'h05);
        do_cmd(8'h41);
        check("dma_en_set", 32'(dma_en), 32'd1);
        check("dma_tgt_set", 32'(dma_tgt), 32'd1);
        do_cmd(8'h89);
        spi_byte_cnt = 32'd3;
        tick();
        mcu_data_in = 8'h5A;
        mcu_rq_rdy  = 1'b1;
        tick();
        dma_nextaddr = 1'b1;
        tick();
        dma_nextaddr = 1'b0;
        check("coll_busy", 32'(busy), 32'd0);
        check("coll_cycle1", ch_addr(1), 32'h6);
        tick();
        check("coll_cycle2", ch_addr(1), 32'h7);
        mcu_rq_rdy = 1'b0;
        tick();
        check("coll_settled", ch_addr(1), 32'h7);
        dma_nextaddr = 1'b1;
        tick();
        dma_nextaddr = 1'b0;
        check("dma_alone", ch_addr(1), 32'h8);

        // Load beats a simultaneous DMA advance
        do_cmd(8'h01);
        dma_nextaddr = 1'b1;
        do_param(8'h77, 2);
        dma_nextaddr = 1'b0;
        check("load_wins", ch_addr(1), 32'h770000);
        tick();
        check("load_wins_hold", ch_addr(1), 32'h770000);

        // Parameter byte under 0x4x clears dma_en
        do_cmd(8'h41);
        do_param(8'h00, 2);
        check("dma_en_clr", 32'(dma_en), 32'd0);

        // Reset during WAIT aborts the request
        tick();
        do_cmd(8'h88);
        tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr0", ch_addr(0), 32'h0);
        rrq_base    = rrq_cnt;
        mcu_data_in = 8'hEE;
        mcu_rq_rdy  = 1'b1;
        repeat (4) tick();
        check("late_rdy_busy", 32'(busy), 32'd0);
        check("late_rdy_addr0", ch_addr(0), 32'h0);
        check("late_rdy_spi", 32'(spi_data_out), 32'h00);
        check("late_rdy_no_rrq", 32'(rrq_cnt - rrq_base), 32'd0);
        mcu_rq_rdy = 1'b0;

        // Limit resets to all-ones: wrap only at 0xFFFFFF
        load3(8'h00, 8'hFF, 8'hFF, 8'hFE);
        dma_nextaddr = 1'b1;
        tick();
        check("rst_lim_step", ch_addr(0), 32'hFFFFFF);
        tick();
        dma_nextaddr = 1'b0;
        check("rst_lim_wrap", ch_addr(0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_cmd_chan.md
MCU_CMD_CHAN -- requirements
Module: mcu_cmd_chan

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NCH, 4, number of address channels (2..16).
- AW, 24, address width per channel (8..32).
- NB, derived ceil(AW/8), address bytes per load.
- TW, derived max(1, clog2(NCH)), channel index width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- cmd_ready, in, 1, cmd_data valid strobe (SPI byte 1).
- param_ready, in, 1, param_data valid strobe (SPI bytes 2+).
- cmd_data, in, 8, current command byte, held for the whole transfer.
- param_data, in, 8, current parameter byte.
- spi_byte_cnt, in, 32, byte index; command = 1, first param = 2.
- mcu_rq_rdy, in, 1, memory-side request completion level.
- mcu_data_in, in, 8, read data from memory.
- dma_nextaddr, in, 1, SD-DMA advance pulse.
- mcu_rrq, out, 1, read request pulse.
- mcu_wrq, out, 1, write request pulse.
- mcu_data_out, out, 8, write data.
- spi_data_out, out, 8, MCU readback byte.
- addr_out, out, NCH*AW, channel addresses; channel c occupies [c*AW +: AW].
- dma_tgt, out, TW, channel advanced by dma_nextaddr.
- dma_en, out, 1, SD-DMA enable.
- busy, out, 1, request FSM not IDLE.

Function
REQ-003 Commands decode on cmd_data[7:4]; channel t = cmd_data[TW-1:0]; t >= NCH is ignored (no state change).
REQ-004 0x0t load: byte 2 SHALL set addr[t] = {param_data, zeros}, MSB-aligned to AW; bytes 3..NB+1 fill successive lower bytes; bytes beyond NB+1 are ignored.
REQ-005 0x5t limit: same byte order loads limit[t].
REQ-006 0x4t: on cmd_ready, dma_tgt <= t and dma_en <= 1; any param_ready under 0x4x SHALL clear dma_en.
REQ-007 0x7t readback: on cmd_ready, snapshot addr[t]; at param byte k (2..NB+1), spi_data_out <= snapshot byte (k-2) counted from MSB; other byte indices give 0x00.
REQ-008 0x8x read / 0x9x write on channel cur = cmd_data[TW-1:0] when NCH <= 8, else channel 0; bit 3 = auto-increment; bit 0 = skip the first transfer's increment.
REQ-009 Request FSM states IDLE, RQ, WAIT:
- IDLE->RQ on cmd_ready or param_ready for 0x8x, or on param_ready for 0x9x (mcu_data_out <= param_data in the same cycle).
- RQ: rrq or wrq high for exactly 1 cycle, then WAIT.
- WAIT->IDLE on the 0->1 edge of mcu_rq_rdy, detected via a 2-flop history; for reads, spi_data_out <= mcu_data_in on that same cycle.
REQ-010 Strobes arriving while not IDLE SHALL be dropped; busy = (state != IDLE).
REQ-011 Increment rules:
- On a WAIT->IDLE transition with auto-increment set and (bit0 == 0 or spi_byte_cnt >= 3), addr[cur] SHALL advance.
- dma_nextaddr SHALL advance addr[dma_tgt].
REQ-012 Advance = (addr == limit) ? 0 : addr + 1, modulo 2^AW.
REQ-013 Each channel advances at most once per cycle. If the MCU and DMA advances hit the same channel in one cycle, the DMA advance applies and the MCU advance is held in a pending flag and applied the next cycle.
REQ-014 A load (0x0t) in the same cycle as an advance of the same channel SHALL win, and any pending advance for that channel is discarded.
REQ-015 All outputs are registered; request latency is strobe -> rrq/wrq high on the next clk edge.

Reset
REQ-016 While rst is high at a clk edge:
- addr = 0 and limit = all-ones for all channels.
- dma_tgt = 0, dma_en = 0.
- FSM = IDLE; rrq = wrq = 0; pending = 0.
- mcu_data_out = 0, spi_data_out = 0, busy = 0, edge history = 0.
REQ-017 Reset in RQ or WAIT SHALL abort the request with no advance; reset overrides all concurrent strobes.

Verification
REQ-018 0x02, params 12 34 56 (AW=24) -> addr[2] = 0x123456; others unchanged.
REQ-019 0x88 on channel 0 with addr 0x00FFFF and limit 0x00FFFF; assert mcu_rq_rdy -> one rrq pulse, spi_data_out = mcu_data_in, addr[0] = 0x000000.
REQ-020 0x41, then dma_nextaddr plus an MCU advance on channel 1 in the same cycle, addr[1] = 5 -> 6 after cycle 1, 7 after cycle 2.
REQ-021 0x71 with addr[1] = 0xABCDEF -> spi_data_out AB, CD, EF at bytes 2..4; 00 at byte 5.
REQ-022 rst pulsed in WAIT -> busy = 0, no advance; a late mcu_rq_rdy edge is ignored.
REQ-023 Strobes during busy, and command 0x0F with NCH=4 -> no state change.
